lane_rr_arbiter: RTL and testbench

Two-lane round-robin arbiter that shares one 8-bit byte path between lane 0 and lane 1 of the PHY transmit side. Each lane's valid bytes go into a small per-lane FIFO. One byte per cycle is granted to the shared output, tagged with its source lane. Per-lane pause flags give backpressure, and sticky overflow flags record any dropped bytes. Idle cycles carry the IDLE_CODE filler.

---
 rtl/lane_rr_arbiter_pkg.sv | 18 +
 rtl/lane_fifo.sv | 52 +++++
 rtl/lane_rr_arbiter.sv | 110 +++++++++++
 tb/tb_lane_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_rr_arbiter_pkg.sv
// Shared widths, filler code and arbiter state encoding for the two-lane
// round-robin arbiter and its lane FIFOs.
package lane_rr_arbiter_pkg;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int ADDR_W      = 2;
    localparam int ALMOST_FULL = 3;

    localparam logic [DATA_W-1:0] IDLE_CODE = 8'hBC;

    // Encodes which lane received the most recent grant.
    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lane_fifo.sv
// Small per-lane byte FIFO. Fullness is judged on the registered count, so a
// full FIFO refuses a write even when it is popped on the same edge.
module lane_fifo
    import lane_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic            clk_2f,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic            rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]     count,
    output logic            empty,
    output logic            full
);

    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_2f) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lane_rr_arbiter.sv
// Two-lane round-robin arbiter sharing one byte path; one byte per cycle is
// popped from a lane FIFO and registered onto data_out with its lane tag.
module lane_rr_arbiter
    import lane_rr_arbiter_pkg::*;
(
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0_c,
    input  logic              valid_in_0_c,
    input  logic [DATA_W-1:0] data_in_1_c,
    input  logic              valid_in_1_c,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              lane_sel_out,
    output logic              pause_0,
    output logic              pause_1,
    output logic              overflow_0,
    output logic              overflow_1,
    output arb_state_t        state_dbg
);

    localparam int CW = ADDR_W + 1;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              grant_valid;
    logic              grant_lane;
    logic              rd_en_0;
    logic              rd_en_1;
    logic [DATA_W-1:0] head_0;
    logic [DATA_W-1:0] head_1;
    logic [CW-1:0]     count_0;
    logic [CW-1:0]     count_1;
    logic              empty_0;
    logic              empty_1;
    logic              full_0;
    logic              full_1;

    lane_fifo u_fifo_0 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .wr_en   (valid_in_0_c),
        .wr_data (data_in_0_c),
        .rd_en   (rd_en_0),
        .rd_data (head_0),
        .count   (count_0),
        .empty   (empty_0),
        .full    (full_0)
    );

    lane_fifo u_fifo_1 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .wr_en   (valid_in_1_c),
        .wr_data (data_in_1_c),
        .rd_en   (rd_en_1),
        .rd_data (head_1),
        .count   (count_1),
        .empty   (empty_1),
        .full    (full_1)
    );

    assign pause_0   = (count_0 >= CW'(ALMOST_FULL));
    assign pause_1   = (count_1 >= CW'(ALMOST_FULL));
    assign state_dbg = state;

    // Reset to LAST1 so lane 0 wins the first tie.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) state <= LAST1;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (grant_valid) state_nxt = grant_lane ? LAST1 : LAST0;
    end

    always_comb begin
        grant_valid = !empty_0 || !empty_1;
        grant_lane  = 1'b0;
        if (!empty_0 && !empty_1) grant_lane = (state == LAST0);
        else                      grant_lane = !empty_1;
        rd_en_0 = grant_valid && !grant_lane;
        rd_en_1 = grant_valid && grant_lane;
    end

    // lane_sel_out keeps the last granted lane across idle cycles.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            data_out     <= IDLE_CODE;
            valid_out    <= 1'b0;
            lane_sel_out <= 1'b0;
        end else begin
            valid_out <= grant_valid;
            data_out  <= grant_valid ? (grant_lane ? head_1 : head_0) : IDLE_CODE;
            if (grant_valid) lane_sel_out <= grant_lane;
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            overflow_0 <= 1'b0;
            overflow_1 <= 1'b0;
        end else begin
            if (valid_in_0_c && full_0) overflow_0 <= 1'b1;
            if (valid_in_1_c && full_1) overflow_1 <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Directed bench for lane_rr_arbiter: stimulus pushes hand-computed bytes and
// due cycles into a queue that a negedge monitor pops against the output.
module tb_lane_rr_arbiter;
    import lane_rr_arbiter_pkg::*;

    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] data_in_0_c, data_in_1_c;
    logic       valid_in_0_c, valid_in_1_c;
    logic [7:0] data_out;
    logic       valid_out, lane_sel_out;
    logic       pause_0, pause_1, overflow_0, overflow_1;
    arb_state_t state_dbg;

    lane_rr_arbiter dut (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .data_in_0_c  (data_in_0_c),
        .valid_in_0_c (valid_in_0_c),
        .data_in_1_c  (data_in_1_c),
        .valid_in_1_c (valid_in_1_c),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .lane_sel_out (lane_sel_out),
        .pause_0      (pause_0),
        .pause_1      (pause_1),
        .overflow_0   (overflow_0),
        .overflow_1   (overflow_1),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk_2f = ~clk_2f;

    int cyc = 0;
    always @(posedge clk_2f) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    int         due_q[$];
    logic       exp_last_lane = 1'b0;
    int         c;
    int         idx0, idx1;
    logic       v0, v1;

    // Output order for both lanes streaming 8 cycles: 0x26 and 0x17 are dropped.
    logic [7:0] t3_exp [14] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13,
                                8'h23, 8'h14, 8'h24, 8'h15, 8'h25, 8'h16, 8'h27};
    // {pause_0, pause_1, overflow_0, overflow_1} seen after each write edge.
    logic [3:0] t3_flags [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                                 4'b1100, 4'b1100, 4'b1101, 4'b1111};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_flags(input logic [3:0] e, input string name);
        check(name, int'({pause_0, pause_1, overflow_0, overflow_1}), int'(e));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, int'(valid_out), 0);
        check({name, "_data"}, int'(data_out), int'(IDLE_CODE));
        check({name, "_lane"}, int'(lane_sel_out), 0);
        check_flags(4'b0000, {name, "_flags"});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic dv0, input logic [7:0] dd0,
                         input logic dv1, input logic [7:0] dd1);
        @(negedge clk_2f);
        valid_in_0_c = dv0;
        data_in_0_c  = dd0;
        valid_in_1_c = dv1;
        data_in_1_c  = dd1;
    endtask

    task automatic push(input logic lane, input logic [7:0] data, input int due);
        exp_q.push_back({lane, data});
        due_q.push_back(due);
    endtask

    task automatic do_reset();
        @(negedge clk_2f);
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_outputs("reset_assert");
        repeat (2) @(negedge clk_2f);
        #1 reset = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk_2f);
        @(negedge clk_2f);
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        due_q.delete();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [8:0] e;
        int         d;
        forever begin
            @(negedge clk_2f);
            if (!reset) exp_last_lane = 1'b0;
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got lane %0d byte 0x%0h, expected idle (cycle %0d)",
                             lane_sel_out, data_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    check("out_lane_byte", int'({lane_sel_out, data_out}), int'(e));
                    check("out_cycle", cyc, d);
                    exp_last_lane = e[8];
                end
            end else begin
                check("idle_code", int'(data_out), int'(IDLE_CODE));
                check("idle_lane_hold", int'(lane_sel_out), int'(exp_last_lane));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b0;
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        data_in_0_c  = 8'h00;
        data_in_1_c  = 8'h00;
        repeat (3) @(negedge clk_2f);
        check_reset_outputs("reset_hold");
        #1 reset = 1'b1;

        // Idle after release
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_2f);
            check_flags(4'b0000, "idle_flags");
        end

        // Lane 0 only
        drive(1'b1, 8'hFF, 1'b0, 8'h00); c = cyc; push(1'b0, 8'hFF, c + 2);
        drive(1'b1, 8'hEE, 1'b0, 8'h00);          push(1'b0, 8'hEE, c + 3);
        drive(1'b1, 8'hDD, 1'b0, 8'h00);          push(1'b0, 8'hDD, c + 4);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        wait_drain("lane0_only");
        check_flags(4'b0000, "lane0_only_flags");

        // Both lanes on the same cycles, lane 0 wins the first tie
        do_reset();
        drive(1'b1, 8'hAA, 1'b1, 8'h05); c = cyc;
        push(1'b0, 8'hAA, c + 2);
        push(1'b1, 8'h05, c + 3);
        drive(1'b1, 8'h99, 1'b1, 8'h06);
        push(1'b0, 8'h99, c + 4);
        push(1'b1, 8'h06, c + 5);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        wait_drain("both_lanes");
        repeat (3) @(negedge clk_2f);

        // Both lanes streaming without honouring pause
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_2f);
            if (i == 0) begin
                c = cyc;
                for (int j = 0; j < 14; j++) push(j % 2 == 1, t3_exp[j], c + 2 + j);
            end
            check_flags(t3_flags[i], "stream_flags");
            valid_in_0_c = (i < 8);
            valid_in_1_c = (i < 8);
            data_in_0_c  = 8'(8'h10 + i);
            data_in_1_c  = 8'(8'h20 + i);
        end
        wait_drain("stream");
        check_flags(4'b0011, "stream_end_flags");

        // Sources stall on pause: nothing dropped, strict alternation
        do_reset();
        idx0 = 0;
        idx1 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_2f);
            if (k == 0) begin
                c = cyc;
                for (int j = 0; j < 16; j++)
                    push(j % 2 == 1, (j % 2 == 1) ? 8'(8'h40 + j / 2) : 8'(8'h30 + j / 2), c + 2 + j);
            end
            v0 = (idx0 < 8) && !pause_0;
            v1 = (idx1 < 8) && !pause_1;
            valid_in_0_c = v0;
            valid_in_1_c = v1;
            data_in_0_c  = 8'(8'h30 + idx0);
            data_in_1_c  = 8'(8'h40 + idx1);
            if (v0) idx0++;
            if (v1) idx1++;
            if (idx0 == 8 && idx1 == 8 && !v0 && !v1) break;
        end
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        check("paced_sent_0", idx0, 8);
        check("paced_sent_1", idx1, 8);
        wait_drain("paced");
        check_flags(4'b0000, "paced_flags");

        // Reset with three bytes queued in lane 1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1, 8'(8'h70 + i));
            if (i == 0) begin
                c = cyc;
                push(1'b0, 8'h60, c + 2);
                push(1'b1, 8'h70, c + 3);
                push(1'b0, 8'h61, c + 4);
            end
        end
        @(negedge clk_2f);
        check_flags(4'b0100, "midreset_pre_flags");
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clk_2f);
        #1 reset = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h07); c = cyc; push(1'b1, 8'h07, c + 2);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (8) @(negedge clk_2f);
        wait_drain("after_midreset");
        check_flags(4'b0000, "final_flags");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
